// File: rtl/key_evt_pkg.sv
// Shared definitions for the key gesture decoder: event codes, FSM states,
// timer limit selection and the ms-to-cycles helper.
package key_evt_pkg;

  localparam logic [2:0] EVT_NONE   = 3'd0;
  localparam logic [2:0] EVT_SINGLE = 3'd1;
  localparam logic [2:0] EVT_DOUBLE = 3'd2;
  localparam logic [2:0] EVT_LONG   = 3'd3;
  localparam logic [2:0] EVT_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT2     = 3'd3,
    ST_WAIT_REL  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LIM_LONG   = 2'd0,
    LIM_DCLICK = 2'd1,
    LIM_REPEAT = 2'd2
  } lim_sel_e;

  function automatic logic [31:0] ms_to_cyc(input int unsigned clk_freq,
                                            input int unsigned ms);
    return 32'((clk_freq / 1000) * ms);
  endfunction

endpackage

// File: rtl/key_evt_timer.sv
// 32-bit gesture timer: synchronous clear, count enable, and a terminal flag
// that is high when the count sits at (selected limit - 1).
module key_evt_timer
  import key_evt_pkg::*;
#(
  parameter logic [31:0] LONG_CYC   = 32'd2,
  parameter logic [31:0] DCLICK_CYC = 32'd2,
  parameter logic [31:0] REPEAT_CYC = 32'd2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr_i,
  input  logic     en_i,
  input  lim_sel_e lim_sel_i,
  output logic     term_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] limit;

  always_comb begin
    limit = LONG_CYC;
    case (lim_sel_i)
      LIM_DCLICK: limit = DCLICK_CYC;
      LIM_REPEAT: limit = REPEAT_CYC;
      default:    limit = LONG_CYC;
    endcase
  end

  assign term_o = (cnt_q == limit - 32'd1);

  // Clear wins over enable so a state change always restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into single/double/long/repeat events and
// emits a registered one-cycle event strobe with a 3-bit code.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       key_hold,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       busy
);

  localparam logic [31:0] LONG_CYC   = ms_to_cyc(CLK_FREQ, LONG_MS);
  localparam logic [31:0] DCLICK_CYC = ms_to_cyc(CLK_FREQ, DCLICK_MS);
  localparam logic [31:0] REPEAT_CYC = ms_to_cyc(CLK_FREQ, REPEAT_MS);

  if (LONG_CYC < 32'd2 || DCLICK_CYC < 32'd2 || REPEAT_CYC < 32'd2) begin : g_bad_timing
    $error("key_event_decoder: every derived cycle constant must be >= 2");
  end

  state_e     state_q, state_d;
  logic [2:0] evt_d;
  logic       evt_valid_q;
  logic [2:0] evt_code_q;
  logic       tmr_clr, tmr_en, tmr_term;
  lim_sel_e   tmr_sel;

  key_evt_timer #(
    .LONG_CYC   (LONG_CYC),
    .DCLICK_CYC (DCLICK_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .lim_sel_i (tmr_sel),
    .term_o    (tmr_term)
  );

  always_comb begin
    state_d = state_q;
    evt_d   = EVT_NONE;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tmr_sel = LIM_LONG;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (key_press) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        tmr_sel = LIM_LONG;
        // Release is tested first so it beats a coincident long-press timeout.
        if (!key_hold) begin
          state_d = ST_WAIT2;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          evt_d   = EVT_LONG;
          state_d = ST_LONG_HELD;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        tmr_sel = LIM_REPEAT;
        if (!key_hold) begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          evt_d   = EVT_REPEAT;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT2: begin
        tmr_sel = LIM_DCLICK;
        if (key_press) begin
          evt_d   = EVT_DOUBLE;
          state_d = ST_WAIT_REL;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          evt_d   = EVT_SINGLE;
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        tmr_clr = 1'b1;
        if (!key_hold) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_NONE;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= (evt_d != EVT_NONE);
      evt_code_q  <= evt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Gesture-level bench: builds a timeline of key activity plus the events and
// busy intervals each gesture must produce, then replays it cycle by cycle.
module tb_key_event_decoder;

  localparam int L = 20;   // long-press cycles
  localparam int D = 10;   // double-click window cycles
  localparam int R = 5;    // repeat period cycles
  localparam int N = 6000;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_press;
  logic       key_hold;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       busy;

  bit         rst_a   [N];
  bit         press_a [N];
  bit         hold_a  [N];
  bit         busy_a  [N];
  logic [2:0] code_a  [N];

  int n_checks = 0;
  int n_errors = 0;

  key_event_decoder #(
    .CLK_FREQ  (1000),
    .LONG_MS   (L),
    .DCLICK_MS (D),
    .REPEAT_MS (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_press (key_press),
    .key_hold  (key_hold),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_range_hold(input int a, input int b);
    for (int i = a; i < b && i < N; i++) hold_a[i] = 1'b1;
  endtask

  task automatic set_range_busy(input int a, input int b);
    for (int i = a; i < b && i < N; i++) busy_a[i] = 1'b1;
  endtask

  // Press at edge p, held for h edges, released and no second press.
  task automatic add_single(input int p, input int h, output int nt);
    int rel;
    rel = p + h;
    press_a[p] = 1'b1;
    set_range_hold(p, rel);
    code_a[rel + D] = 3'd1;
    set_range_busy(p, rel + D);
    nt = rel + D + 1;
  endtask

  // First press held h1, gap g after release, second press held h2.
  task automatic add_double(input int p, input int h1, input int g, input int h2,
                            output int nt);
    int q;
    q = p + h1 + g;
    press_a[p] = 1'b1;
    set_range_hold(p, p + h1);
    press_a[q] = 1'b1;
    set_range_hold(q, q + h2);
    code_a[q] = 3'd2;
    set_range_busy(p, q + h2);
    nt = q + h2 + 1;
  endtask

  // Press held h > L edges: LONG at L, then REPEAT every R while still held.
  task automatic add_long(input int p, input int h, output int nt);
    press_a[p] = 1'b1;
    set_range_hold(p, p + h);
    code_a[p + L] = 3'd3;
    for (int m = 1; L + m * R < h; m++) code_a[p + L + m * R] = 3'd4;
    set_range_busy(p, p + h);
    nt = p + h + 1;
  endtask

  // Reset pulse while counting in the first press; key stays held well past
  // the long-press time, which must be ignored once idle.
  task automatic add_reset_abort(input int p, output int nt);
    press_a[p] = 1'b1;
    set_range_hold(p, p + 40);
    rst_a[p + 16] = 1'b1;
    set_range_busy(p, p + 16);
    nt = p + 41;
  endtask

  task automatic check_cycle(input int k);
    if (code_a[k] != 3'd0 || evt_valid)
      $display("cyc %0d: evt_valid=%0b code=%0d expected code=%0d busy=%0b",
               k, evt_valid, evt_code, code_a[k], busy);
    check("evt_valid", int'(evt_valid), int'(code_a[k] != 3'd0));
    check("evt_code", int'(evt_code), int'(code_a[k]));
    check("busy", int'(busy), int'(busy_a[k]));
  endtask

  initial begin
    int t;
    int kind;
    for (int i = 0; i < N; i++) begin
      rst_a[i] = 1'b0; press_a[i] = 1'b0; hold_a[i] = 1'b0;
      busy_a[i] = 1'b0; code_a[i] = 3'd0;
    end
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b1;

    t = 5;
    add_single(t, 3, t);           t += 2;
    add_double(t, 3, 4, 6, t);     t += 2;
    add_long(t, 32, t);            t += 2;
    add_single(t, L, t);           t += 2;  // release exactly at the long boundary
    add_double(t, 5, D, 3, t);     t += 2;  // second press on the timeout edge
    add_reset_abort(t, t);         t += 2;
    add_long(t, L + 1, t);         t += 1;

    while (t < N - 120) begin
      kind = $urandom_range(0, 2);
      case (kind)
        0: add_single(t, $urandom_range(1, L), t);
        1: add_double(t, $urandom_range(1, L), $urandom_range(1, D),
                      $urandom_range(1, 25), t);
        default: add_long(t, $urandom_range(L + 1, L + 3 * R + 3), t);
      endcase
      t += $urandom_range(0, 4);
    end

    rst = rst_a[0]; key_press = press_a[0]; key_hold = hold_a[0];
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      check_cycle(k - 1);
      rst = rst_a[k]; key_press = press_a[k]; key_hold = hold_a[k];
    end
    @(negedge clk);
    check_cycle(N - 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced `key_press` (1-cycle pulse) and `key_hold` (level) from the key debouncer.
- Classifies each gesture as one of: single click, double click, long press, or auto-repeat while held.
- Emits one registered event pulse with a 3-bit code.
- Sits between the key front-end and the SM4 control/mode-select logic, so that logic never sees raw key timing.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz
- LONG_MS, 1000, hold time in ms before a long-press event
- DCLICK_MS, 300, max release-to-second-press gap in ms for a double click
- REPEAT_MS, 200, repeat-event period in ms while held after a long press

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key_press  in  1  debounced press pulse, one cycle per press
- key_hold  in  1  debounced pressed level, 1 = pressed
- evt_valid  out  1  one-cycle event strobe
- evt_code  out  3  event code, valid when evt_valid=1; 0 otherwise
- busy  out  1  1 when state != IDLE

Behaviour:
- Reset is synchronous and active-high. `rst`=1 at a clk edge forces the following:
  - state=IDLE, cnt=0, evt_valid=0, evt_code=0
  - busy=0, combinational from state
  - This applies mid-gesture too: no event is emitted for an aborted gesture.
- Cycle constants are computed at elaboration, 32-bit:
  - LONG_CYC = (CLK_FREQ/1000)*LONG_MS
  - DCLICK_CYC = (CLK_FREQ/1000)*DCLICK_MS
  - REPEAT_CYC = (CLK_FREQ/1000)*REPEAT_MS
  - Each must be >= 2 (elaboration check).
- Counter `cnt` is 32-bit, counts up from 0. A terminal event fires when cnt == X_CYC-1, and cnt clears on every state change.
- Event codes: SINGLE=1, DOUBLE=2, LONG=3, REPEAT=4.
- Event timing:
  - Events are registered: evt_valid/evt_code are asserted the cycle after the deciding edge, for exactly one cycle.
  - At most one event per cycle.
- States and transitions:
  - IDLE: key_press=1 -> PRESS1. key_hold alone (without key_press) is ignored.
  - PRESS1:
    - key_hold=0 -> WAIT2.
    - Else if cnt==LONG_CYC-1 -> emit LONG, go to LONG_HELD.
    - Else cnt++.
  - LONG_HELD:
    - key_hold=0 -> IDLE, no event.
    - Else if cnt==REPEAT_CYC-1 -> emit REPEAT, cnt=0.
    - Else cnt++.
  - WAIT2:
    - key_press=1 -> emit DOUBLE, go to WAIT_REL. This has priority over timeout in the same cycle.
    - Else if cnt==DCLICK_CYC-1 -> emit SINGLE, go to IDLE.
    - Else cnt++.
  - WAIT_REL: key_hold=0 -> IDLE. A held second press never yields LONG or REPEAT.
- Boundary conditions:
  - In PRESS1, key_hold falling in the same cycle cnt reaches LONG_CYC-1: release wins -> WAIT2, no LONG.
  - key_press arriving in PRESS1/LONG_HELD/WAIT_REL is ignored (not possible from the debouncer).
  - A third press inside the window after a DOUBLE starts a new gesture from IDLE only after release.
  - Counter never wraps: every state bounds it by a terminal compare.

Decomposition:
- Package key_evt_pkg holds:
  - event code localparams EVT_NONE/SINGLE/DOUBLE/LONG/REPEAT
  - state encoding (IDLE, PRESS1, LONG_HELD, WAIT2, WAIT_REL; 3 bits)
  - the ms-to-cycles constant function
- One natural sub-module, key_evt_timer:
  - 32-bit counter with synchronous clear, enable, and a terminal-compare output against a selected limit.
  - The FSM drives its clear and limit select.

Test Plan (CLK_FREQ=1000, LONG_MS=20, DCLICK_MS=10, REPEAT_MS=5, i.e. 1 cycle = 1 ms):
- Press held 3 cycles, released, no further press -> one evt_code=1 pulse exactly 10 cycles after release, busy back to 0 the next cycle.
- Press 3 cycles, release 4 cycles, press again -> evt_code=2 one cycle after the second key_press. No SINGLE. Releasing returns to IDLE.
- Press held 32 cycles -> evt_code=3 at cycle 20 after press, evt_code=4 at cycles 25 and 30. Release -> no further events.
- Release on the exact cycle cnt==19 in PRESS1 -> no LONG. SINGLE after a 10-cycle window.
- Second key_press on the same cycle as the WAIT2 timeout -> evt_code=2 only, never 1.
- rst=1 for one cycle mid-PRESS1 (cnt=15), then release -> evt_valid stays 0 throughout, state IDLE, busy=0 after the reset edge.
